// File: rtl/tile_fetch_sched.sv
// -----------------------------------------------------------------------------
// tile_fetch_sched
//
// Walks a frame in raster order, one tile at a time. For each tile it issues
// two DMA read requests: first the motion region (the tile itself), then the
// reference region (the tile grown by a halo on every side, read from the
// reference frame). All address and length arithmetic wraps modulo 2^ADDR_W.
// The halo subtraction is not clamped at the frame edge.
//
// Ports
//   clk                 : clock; all state updates on the rising edge
//   rst_n               : synchronous active-low reset
//   start               : one-cycle pulse starting a frame; only seen in IDLE
//   frame_base_addr     : byte base of the current frame
//   ref_base_addr       : byte base of the reference frame
//   frame_stride_bytes  : row pitch in bytes
//   bytes_per_pixel     : pixel size in bytes
//   frame_rows/cols     : frame size in pixels
//   tile_rows/cols      : tile size in pixels
//   halo                : reference halo in pixels
//   req_valid/req_ready : DMA request handshake
//   req_addr, req_len   : request start byte address and byte length
//   req_is_ref          : 0 = motion region, 1 = reference region
//   tile_row, tile_col  : pixel origin of the tile being fetched
//   busy                : high in every state except IDLE
//   done                : one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module tile_fetch_sched #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_base_addr,
    input  logic [ADDR_W-1:0] ref_base_addr,
    input  logic [15:0]       frame_stride_bytes,
    input  logic [15:0]       bytes_per_pixel,
    input  logic [15:0]       frame_rows,
    input  logic [15:0]       frame_cols,
    input  logic [15:0]       tile_rows,
    input  logic [15:0]       tile_cols,
    input  logic [15:0]       halo,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0] req_len,
    output logic              req_is_ref,
    output logic [15:0]       tile_row,
    output logic [15:0]       tile_col,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_REQ_MOT = 3'd2,
        ST_REQ_REF = 3'd3,
        ST_ADV     = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    // Zero-extend a 16-bit pixel/byte quantity to address width.
    function automatic logic [ADDR_W-1:0] zext16(input logic [15:0] v);
        zext16 = ADDR_W'(v);
    endfunction

    state_t state_r;
    state_t state_s;

    // Configuration captured when start is accepted
    logic [ADDR_W-1:0] frame_base_r;
    logic [ADDR_W-1:0] ref_base_r;
    logic [15:0]       stride_r;
    logic [15:0]       bpp_r;
    logic [15:0]       frame_rows_r;
    logic [15:0]       frame_cols_r;
    logic [15:0]       tile_rows_r;
    logic [15:0]       tile_cols_r;
    logic [15:0]       halo_r;

    // Reference request parked here while the motion request is outstanding
    logic [ADDR_W-1:0] ref_addr_r;
    logic [ADDR_W-1:0] ref_len_r;

    // Registered outputs
    logic              req_valid_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [ADDR_W-1:0] req_len_r;
    logic              req_is_ref_r;
    logic [15:0]       tile_row_r;
    logic [15:0]       tile_col_r;
    logic              busy_r;
    logic              done_r;

    logic              cfg_zero_s;
    logic              handshake_s;
    logic [16:0]       next_col_s;
    logic [16:0]       next_row_s;
    logic              col_wrap_s;
    logic              last_tile_s;
    logic [ADDR_W-1:0] mot_addr_s;
    logic [ADDR_W-1:0] mot_len_s;
    logic [ADDR_W-1:0] ref_addr_s;
    logic [ADDR_W-1:0] ref_len_s;
    logic [ADDR_W-1:0] halo2_s;

    // Degenerate-geometry detect on live inputs, handshake and traversal step
    always_comb begin
        cfg_zero_s  = (tile_rows == 16'd0) || (tile_cols == 16'd0) ||
                      (frame_rows == 16'd0) || (frame_cols == 16'd0);
        handshake_s = req_valid_r && req_ready;
        // 17-bit sums so that stepping past 65535 terminates instead of wrapping
        next_col_s  = {1'b0, tile_col_r} + {1'b0, tile_cols_r};
        next_row_s  = {1'b0, tile_row_r} + {1'b0, tile_rows_r};
        col_wrap_s  = (next_col_s >= {1'b0, frame_cols_r});
        last_tile_s = col_wrap_s && (next_row_s >= {1'b0, frame_rows_r});
    end

    // Request address/length arithmetic for the current tile (mod 2^ADDR_W)
    always_comb begin
        halo2_s    = zext16(halo_r) + zext16(halo_r);
        mot_addr_s = frame_base_r
                   + zext16(tile_row_r) * zext16(stride_r)
                   + zext16(tile_col_r) * zext16(bpp_r);
        mot_len_s  = zext16(tile_rows_r) * zext16(tile_cols_r) * zext16(bpp_r);
        ref_addr_s = ref_base_r
                   + (zext16(tile_row_r) - zext16(halo_r)) * zext16(stride_r)
                   + (zext16(tile_col_r) - zext16(halo_r)) * zext16(bpp_r);
        ref_len_s  = (zext16(tile_rows_r) + halo2_s)
                   * (zext16(tile_cols_r) + halo2_s)
                   * zext16(bpp_r);
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_zero_s) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_CALC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: state_s = ST_REQ_MOT;
            ST_REQ_MOT: begin
                if (handshake_s) begin
                    state_s = ST_REQ_REF;
                end else begin
                    state_s = ST_REQ_MOT;
                end
            end
            ST_REQ_REF: begin
                if (handshake_s) begin
                    state_s = ST_ADV;
                end else begin
                    state_s = ST_REQ_REF;
                end
            end
            ST_ADV: begin
                if (last_tile_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Configuration capture, request payload and tile origin registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_base_r <= '0;
            ref_base_r   <= '0;
            stride_r     <= 16'd0;
            bpp_r        <= 16'd0;
            frame_rows_r <= 16'd0;
            frame_cols_r <= 16'd0;
            tile_rows_r  <= 16'd0;
            tile_cols_r  <= 16'd0;
            halo_r       <= 16'd0;
            ref_addr_r   <= '0;
            ref_len_r    <= '0;
            req_addr_r   <= '0;
            req_len_r    <= '0;
            req_is_ref_r <= 1'b0;
            tile_row_r   <= 16'd0;
            tile_col_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        frame_base_r <= frame_base_addr;
                        ref_base_r   <= ref_base_addr;
                        stride_r     <= frame_stride_bytes;
                        bpp_r        <= bytes_per_pixel;
                        frame_rows_r <= frame_rows;
                        frame_cols_r <= frame_cols;
                        tile_rows_r  <= tile_rows;
                        tile_cols_r  <= tile_cols;
                        halo_r       <= halo;
                        tile_row_r   <= 16'd0;
                        tile_col_r   <= 16'd0;
                    end
                end
                ST_CALC: begin
                    req_addr_r   <= mot_addr_s;
                    req_len_r    <= mot_len_s;
                    req_is_ref_r <= 1'b0;
                    ref_addr_r   <= ref_addr_s;
                    ref_len_r    <= ref_len_s;
                end
                ST_REQ_MOT: begin
                    // Payload only moves on the handshake, so it holds under backpressure
                    if (handshake_s) begin
                        req_addr_r   <= ref_addr_r;
                        req_len_r    <= ref_len_r;
                        req_is_ref_r <= 1'b1;
                    end
                end
                ST_ADV: begin
                    // On the final tile the origin keeps its last in-frame value
                    if (!last_tile_s) begin
                        if (col_wrap_s) begin
                            tile_col_r <= 16'd0;
                            tile_row_r <= next_row_s[15:0];
                        end else begin
                            tile_col_r <= next_col_s[15:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs registered from the next state so they track the state exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            req_valid_r <= (state_s == ST_REQ_MOT) || (state_s == ST_REQ_REF);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_FIN);
        end
    end

    assign req_valid  = req_valid_r;
    assign req_addr   = req_addr_r;
    assign req_len    = req_len_r;
    assign req_is_ref = req_is_ref_r;
    assign tile_row   = tile_row_r;
    assign tile_col   = tile_col_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_tile_fetch_sched.sv
// -----------------------------------------------------------------------------
// tb_tile_fetch_sched
//
// Self-checking bench for tile_fetch_sched. A table of frame configurations
// with hand-computed first requests and request counts is run through the
// DUT, every frame is also compared request-by-request with a reference model
// that enumerates tiles with plain nested loops, and a few hand-written
// sequences cover backpressure, reset mid-frame and reset state. Randomized
// configurations and random req_ready complete the run.
// -----------------------------------------------------------------------------
module tb_tile_fetch_sched;

    typedef struct {
        logic [31:0] fb;
        logic [31:0] rb;
        logic [15:0] stride;
        logic [15:0] bpp;
        logic [15:0] fr;
        logic [15:0] fc;
        logic [15:0] tr;
        logic [15:0] tc;
        logic [15:0] halo;
    } cfg_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic        is_ref;
        logic [15:0] row;
        logic [15:0] col;
    } req_t;

    typedef struct {
        cfg_t        cfg;
        int          exp_cnt;
        logic [31:0] mot0;
        logic [31:0] mot_len;
        logic [31:0] ref0;
        logic [31:0] ref_len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] frame_base_addr;
    logic [31:0] ref_base_addr;
    logic [15:0] frame_stride_bytes;
    logic [15:0] bytes_per_pixel;
    logic [15:0] frame_rows;
    logic [15:0] frame_cols;
    logic [15:0] tile_rows;
    logic [15:0] tile_cols;
    logic [15:0] halo;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_len;
    logic        req_is_ref;
    logic [15:0] tile_row;
    logic [15:0] tile_col;
    logic        busy;
    logic        done;

    int   checks = 0;
    int   failures = 0;
    req_t obs_q[$];
    req_t exp_q[$];
    int   valid_cycles;
    int   done_cnt;
    int   first_valid_i;
    bit   finished;
    vec_t vecs[7];
    cfg_t spec_cfg;

    always #5 clk = ~clk;

    tile_fetch_sched #(.ADDR_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .frame_base_addr    (frame_base_addr),
        .ref_base_addr      (ref_base_addr),
        .frame_stride_bytes (frame_stride_bytes),
        .bytes_per_pixel    (bytes_per_pixel),
        .frame_rows         (frame_rows),
        .frame_cols         (frame_cols),
        .tile_rows          (tile_rows),
        .tile_cols          (tile_cols),
        .halo               (halo),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_addr           (req_addr),
        .req_len            (req_len),
        .req_is_ref         (req_is_ref),
        .tile_row           (tile_row),
        .tile_col           (tile_col),
        .busy               (busy),
        .done               (done)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: enumerate tiles in raster order and compute each request
    task automatic build_model(input cfg_t c);
        longint fbl, rbl, st, bp, h, trl, tcl, a;
        req_t   m;
        exp_q.delete();
        if (c.fr == 16'd0 || c.fc == 16'd0 || c.tr == 16'd0 || c.tc == 16'd0) return;
        fbl = c.fb; rbl = c.rb; st = c.stride; bp = c.bpp; h = c.halo;
        trl = c.tr; tcl = c.tc;
        for (longint r = 0; r < longint'(c.fr); r += trl) begin
            for (longint k = 0; k < longint'(c.fc); k += tcl) begin
                m.row = r[15:0];
                m.col = k[15:0];
                a = fbl + r * st + k * bp;
                m.addr = a[31:0];
                a = trl * tcl * bp;
                m.len = a[31:0];
                m.is_ref = 1'b0;
                exp_q.push_back(m);
                a = rbl + (r - h) * st + (k - h) * bp;
                m.addr = a[31:0];
                a = (trl + 2 * h) * (tcl + 2 * h) * bp;
                m.len = a[31:0];
                m.is_ref = 1'b1;
                exp_q.push_back(m);
            end
        end
    endtask

    task automatic apply_cfg(input cfg_t c);
        frame_base_addr    = c.fb;
        ref_base_addr      = c.rb;
        frame_stride_bytes = c.stride;
        bytes_per_pixel    = c.bpp;
        frame_rows         = c.fr;
        frame_cols         = c.fc;
        tile_rows          = c.tr;
        tile_cols          = c.tc;
        halo               = c.halo;
    endtask

    task automatic scramble_cfg();
        frame_base_addr    = $urandom;
        ref_base_addr      = $urandom;
        frame_stride_bytes = 16'($urandom);
        bytes_per_pixel    = 16'($urandom);
        frame_rows         = 16'($urandom);
        frame_cols         = 16'($urandom);
        tile_rows          = 16'($urandom);
        tile_cols          = 16'($urandom);
        halo               = 16'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        req_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        req_ready = 1'b0;
        check("return_to_idle", busy, 0);
    endtask

    // Run one frame, collect handshakes, and compare against the model
    task automatic run_frame(input cfg_t c, input int pct, input bit extra_start);
        bit          pv, pr, phs_ref, pisref;
        logic [31:0] paddr, plen;
        req_t        s;
        obs_q.delete();
        valid_cycles = 0; done_cnt = 0; first_valid_i = -1; finished = 0;
        build_model(c);
        apply_cfg(c);
        pulse_start();
        scramble_cfg();
        pv = 0; pr = 0; phs_ref = 0; pisref = 0; paddr = '0; plen = '0;
        for (int i = 0; i < 20000; i++) begin
            if (pv && !pr) begin
                check("hold_valid", {req_valid, req_is_ref}, {1'b1, pisref});
                check("hold_payload", {req_addr, req_len}, {paddr, plen});
            end
            if (phs_ref) check("bubble_after_ref", req_valid, 0);
            if (done) done_cnt++;
            if (!busy) begin
                finished = 1;
                break;
            end
            req_ready = ($urandom_range(0, 99) < pct);
            start = extra_start && (i == 6);
            if (req_valid) begin
                valid_cycles++;
                if (first_valid_i < 0) first_valid_i = i;
                if (req_ready) begin
                    s.addr = req_addr; s.len = req_len; s.is_ref = req_is_ref;
                    s.row = tile_row; s.col = tile_col;
                    obs_q.push_back(s);
                end
            end
            pv = req_valid; pr = req_ready; pisref = req_is_ref;
            paddr = req_addr; plen = req_len;
            phs_ref = req_valid && req_ready && req_is_ref;
            @(posedge clk); #1;
        end
        start = 1'b0;
        req_ready = 1'b0;
        check("frame_end_reached", finished, 1);
        check("done_pulses", done_cnt, 1);
        check("req_count_vs_model", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check("req_addr", obs_q[i].addr, exp_q[i].addr);
            check("req_len", obs_q[i].len, exp_q[i].len);
            check("req_is_ref", obs_q[i].is_ref, exp_q[i].is_ref);
            check("tile_origin", {obs_q[i].row, obs_q[i].col}, {exp_q[i].row, exp_q[i].col});
        end
        if (exp_q.size() > 0) check("first_req_latency", first_valid_i, 1);
        else check("no_valid_degenerate", valid_cycles, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_t c;
        int   hs;

        spec_cfg = '{32'h1000_0000, 32'h2000_0000, 16'd640, 16'd2, 16'd8, 16'd16, 16'd4, 16'd8, 16'd1};
        vecs[0] = '{spec_cfg, 8, 32'h1000_0000, 32'd64, 32'h1FFF_FD7E, 32'd120};
        vecs[1] = '{'{32'h1000_0000, 32'h2000_0000, 16'd640, 16'd2, 16'd8, 16'd16, 16'd4, 16'd0, 16'd1},
                    0, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[2] = '{'{32'h0000_0100, 32'h0000_0200, 16'd100, 16'd1, 16'd5, 16'd10, 16'd4, 16'd8, 16'd0},
                    8, 32'h0000_0100, 32'd32, 32'h0000_0200, 32'd32};
        vecs[3] = '{'{32'h0000_0000, 32'h0000_0040, 16'd8, 16'd4, 16'd2, 16'd2, 16'd16, 16'd16, 16'd2},
                    2, 32'h0000_0000, 32'd1024, 32'h0000_0028, 32'd1600};
        vecs[4] = '{'{32'h1000_0000, 32'h2000_0000, 16'd640, 16'd2, 16'd0, 16'd16, 16'd4, 16'd8, 16'd1},
                    0, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[5] = '{'{32'h0000_5000, 32'h0000_6000, 16'd0, 16'd1, 16'd1, 16'd65535, 16'd1, 16'd40000, 16'd0},
                    4, 32'h0000_5000, 32'd40000, 32'h0000_6000, 32'd40000};
        vecs[6] = '{'{32'hFFFF_FFF0, 32'h0000_0008, 16'd16, 16'd1, 16'd4, 16'd4, 16'd2, 16'd2, 16'd1},
                    8, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF7, 32'd16};

        // Reset state
        rst_n = 1'b0; start = 1'b0; req_ready = 1'b0;
        apply_cfg(spec_cfg);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", req_valid, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_req_len", req_len, 0);
        check("rst_req_is_ref", req_is_ref, 0);
        check("rst_tile_row", tile_row, 0);
        check("rst_tile_col", tile_col, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames; the first also gets a stray start mid-frame
        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].cfg, 100, v == 0);
            check("table_req_count", obs_q.size(), vecs[v].exp_cnt);
            if (vecs[v].exp_cnt > 0 && obs_q.size() >= 2) begin
                check("table_mot_addr", obs_q[0].addr, vecs[v].mot0);
                check("table_mot_len", obs_q[0].len, vecs[v].mot_len);
                check("table_ref_addr", obs_q[1].addr, vecs[v].ref0);
                check("table_ref_len", obs_q[1].len, vecs[v].ref_len);
            end
            check("table_busy_after", busy, 0);
        end

        // Backpressure on the first request for 5 cycles
        apply_cfg(spec_cfg);
        req_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            if (req_valid) break;
            @(posedge clk); #1;
        end
        check("bp_valid_seen", req_valid, 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", {req_valid, req_is_ref, req_addr, req_len},
                  {1'b1, 1'b0, 32'h1000_0000, 32'd64});
            @(posedge clk); #1;
        end
        req_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_resume_ref", {req_valid, req_is_ref, req_addr, req_len},
              {1'b1, 1'b1, 32'h1FFF_FD7E, 32'd120});
        wait_idle(200);

        // Reset during the third request, then a fresh frame
        apply_cfg(spec_cfg);
        req_ready = 1'b1;
        pulse_start();
        hs = 0;
        for (int i = 0; i < 100; i++) begin
            if (req_valid && hs == 2) break;
            if (req_valid) hs++;
            @(posedge clk); #1;
        end
        check("third_req_addr", {req_valid, req_addr}, {1'b1, 32'h1000_0010});
        rst_n = 1'b0;
        req_ready = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_outputs", {req_valid, req_addr, req_len, req_is_ref},
              {1'b0, 32'd0, 32'd0, 1'b0});
        check("mid_rst_status", {tile_row, tile_col, busy, done}, {16'd0, 16'd0, 1'b0, 1'b0});
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(spec_cfg, 100, 1'b0);
        if (obs_q.size() > 0) check("restart_first_addr", obs_q[0].addr, 32'h1000_0000);
        else check("restart_has_requests", obs_q.size(), 8);

        // Randomized frames with random backpressure
        for (int n = 0; n < 8; n++) begin
            c.fb     = $urandom;
            c.rb     = $urandom;
            c.stride = 16'($urandom);
            c.bpp    = 16'($urandom);
            c.fr     = 16'($urandom_range(0, 20));
            c.fc     = 16'($urandom_range(0, 20));
            c.tr     = 16'($urandom_range(0, 7));
            c.tc     = 16'($urandom_range(0, 7));
            c.halo   = 16'($urandom_range(0, 3));
            run_frame(c, 60, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_fetch_sched.md
TILE_FETCH_SCHED -- requirements
Module: tile_fetch_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of all byte addresses and lengths.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1: one-cycle pulse that begins a frame fetch; sampled only in IDLE.
REQ-005 SHALL have ports frame_base_addr, ref_base_addr  input  ADDR_W: base of the current frame and of the reference frame.
REQ-006 SHALL have ports frame_stride_bytes, bytes_per_pixel  input  16: row pitch in bytes and pixel size in bytes.
REQ-007 SHALL have ports frame_rows, frame_cols, tile_rows, tile_cols, halo  input  16: frame size in pixels, tile size in pixels, and reference halo in pixels.
REQ-008 SHALL have port req_valid  output  1: DMA request valid.
REQ-009 SHALL have port req_ready  input  1: DMA accepts the request when it is high together with req_valid.
REQ-010 SHALL have ports req_addr, req_len  output  ADDR_W: request start byte address and byte length.
REQ-011 SHALL have port req_is_ref  output  1: 0 = motion region, 1 = reference region.
REQ-012 SHALL have ports tile_row, tile_col  output  16: pixel origin of the tile being fetched.
REQ-013 SHALL have ports busy  output  1, and done  output  1 (one-cycle pulse at end of frame).

Function
REQ-014 SHALL latch all configuration inputs on the cycle start is accepted; input changes while busy SHALL have no effect.
REQ-015 SHALL implement the states IDLE, CALC, REQ_MOT, REQ_REF, ADV and FIN.
- IDLE -> CALC on start.
- CALC -> REQ_MOT after one cycle.
- REQ_MOT -> REQ_REF on handshake.
- REQ_REF -> ADV on handshake.
- ADV -> CALC if tiles remain, otherwise -> FIN.
- FIN -> IDLE after one cycle.
REQ-016 SHALL raise req_valid on the second cycle after start is sampled (start seen at edge T; req_valid high during cycle T+1 to T+2).
REQ-017 In CALC, SHALL register the motion address: frame_base_addr + tile_row*frame_stride_bytes + tile_col*bytes_per_pixel.
REQ-018 In CALC, SHALL register the motion length: tile_rows*tile_cols*bytes_per_pixel.
REQ-019 In CALC, SHALL register the reference address: ref_base_addr + (tile_row-halo)*frame_stride_bytes + (tile_col-halo)*bytes_per_pixel.
REQ-020 In CALC, SHALL register the reference length: (tile_rows+2*halo)*(tile_cols+2*halo)*bytes_per_pixel.
REQ-021 All address and length arithmetic SHALL be modulo 2^ADDR_W.
- The halo subtraction SHALL wrap and is not clamped at the frame edge.
REQ-022 req_addr, req_len and req_is_ref SHALL stay stable while req_valid=1 and req_ready=0.
- req_valid SHALL NOT drop before the handshake.
REQ-023 req_valid SHALL be 0 in IDLE, CALC, ADV and FIN, so each tile has a one-cycle bubble.
REQ-024 Tile traversal SHALL be raster order, starting at tile_row=0, tile_col=0.
- ADV: tile_col += tile_cols.
- If the new tile_col >= frame_cols: tile_col = 0 and tile_row += tile_rows.
- Traversal ends when the new tile_row >= frame_rows.
- Partial edge tiles SHALL be issued with the full tile size.
REQ-025 Row and column counters SHALL be computed 17 bits wide so that overflow past 65535 ends traversal rather than wrapping.
REQ-026 If tile_rows, tile_cols, frame_rows or frame_cols is 0 at start, the block SHALL go IDLE -> FIN with no request, and done SHALL pulse.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 done SHALL be 1 only in FIN.
REQ-029 start asserted while busy SHALL be ignored.
- start coincident with the FIN cycle SHALL be ignored.

Reset
REQ-030 With rst_n=0 at a clock edge, the block SHALL enter IDLE and drive all outputs to 0: req_valid, req_addr, req_len, req_is_ref, tile_row, tile_col, busy, done.
REQ-031 Reset mid-operation SHALL abandon the outstanding request with no further handshake; the next start SHALL restart from tile (0,0).

Verification
REQ-032 Basic two-request sequence. Stimulus: frame_base_addr=0x1000_0000, ref_base_addr=0x2000_0000, stride=640, bpp=2, frame 8x16, tile 4x8, halo=1, req_ready tied 1. Required response:
- First request: addr 0x1000_0000, len 64, is_ref=0.
- Second request: addr 0x1FFF_FD7E, len 120, is_ref=1.
REQ-033 Same setup: exactly 8 requests are issued, then done pulses once.
- Motion addresses in order: 0x1000_0000, 0x1000_0010, 0x1000_0A00, 0x1000_0A10.
REQ-034 Backpressure. Stimulus: req_ready held 0 for 5 cycles during the first request. Required response: req_valid, addr and len unchanged for all 5 cycles; sequence resumes on the cycle req_ready=1.
REQ-035 Degenerate tile. Stimulus: tile_cols=0 at start. Required response: no req_valid; done pulses exactly once; busy returns to 0.
REQ-036 Reset mid-frame. Stimulus: rst_n=0 during the third request. Required response: all outputs 0 on the next edge; a fresh start re-issues 0x1000_0000 first.
REQ-037 Start while busy. Stimulus: second start pulse mid-frame. Required response: ignored; request count stays 8.
